// File: rtl/tetris_pkg.sv
// Shared types and colours for the board renderer: piece kind, palette and fixed colours.
package tetris_pkg;

   typedef logic [2:0] kind_t;

   localparam logic [11:0] ColBg   = 12'h000;
   localparam logic [11:0] ColGrid = 12'h333;
   localparam logic [11:0] ColK1   = 12'h09D;
   localparam logic [11:0] ColK2   = 12'h04F;
   localparam logic [11:0] ColK3   = 12'hD90;
   localparam logic [11:0] ColK4   = 12'hFF0;
   localparam logic [11:0] ColK5   = 12'h0F3;
   localparam logic [11:0] ColK6   = 12'h80C;
   localparam logic [11:0] ColK7   = 12'hF00;

   // Kind 0 is an empty cell and renders as background.
   function automatic logic [11:0] palette(kind_t kind);
      logic [11:0] col;
      case (kind)
         3'd1:    col = ColK1;
         3'd2:    col = ColK2;
         3'd3:    col = ColK3;
         3'd4:    col = ColK4;
         3'd5:    col = ColK5;
         3'd6:    col = ColK6;
         3'd7:    col = ColK7;
         default: col = ColBg;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/pix_delay.sv
// Pixel-strobe enabled shift register used to align side-band signals with the read path.
module pix_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en_i) begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/board_renderer.sv
// Board-area pixel renderer: cell counters, board read address, latency-aligned palette lookup.
// Define BOARD_RENDER_GRIDLINE_EN to draw grid lines on the first column/row of every cell.
module board_renderer
   import tetris_pkg::*;
#(
   parameter int unsigned ORG_X  = 220,
   parameter int unsigned ORG_Y  = 40,
   parameter int unsigned CELL   = 20,
   parameter int unsigned COLS   = 10,
   parameter int unsigned ROWS   = 20,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      p_tick,
   input  logic [9:0]                pixel_x,
   input  logic [9:0]                pixel_y,
   input  logic                      visible,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   output logic [$clog2(COLS)-1:0]   cell_x,
   output logic [$clog2(ROWS)-1:0]   cell_y,
   input  logic [2:0]                cell_kind,
   output logic                      hsync_out,
   output logic                      vsync_out,
   output logic [11:0]               rgb
);

   localparam int unsigned CxW  = $clog2(COLS);
   localparam int unsigned CyW  = $clog2(ROWS);
   localparam int unsigned ColW = $clog2(COLS + 1);
   localparam int unsigned RowW = $clog2(ROWS + 1);
   localparam int unsigned SubW = $clog2(CELL);

   localparam logic [9:0]      OrgX    = 10'(ORG_X);
   localparam logic [9:0]      OrgY    = 10'(ORG_Y);
   localparam logic [ColW-1:0] ColsOut = ColW'(COLS);
   localparam logic [RowW-1:0] RowsOut = RowW'(ROWS);
   localparam logic [SubW-1:0] SubLast = SubW'(CELL - 1);

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic [SubW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;

   // Stage 0: incremental cell/sub-pixel counters, no divide on the pixel path.
   always_comb begin
      col_d   = col_q;
      sub_x_d = sub_x_q;
      row_d   = row_q;
      sub_y_d = sub_y_q;
      if (pixel_x == OrgX) begin
         col_d   = '0;
         sub_x_d = '0;
      end else if (pixel_x == 10'd0) begin
         col_d   = ColsOut;
         sub_x_d = '0;
      end else if (col_q < ColsOut) begin
         if (sub_x_q == SubLast) begin
            sub_x_d = '0;
            col_d   = col_q + 1'b1;
         end else begin
            sub_x_d = sub_x_q + 1'b1;
         end
      end
      if (pixel_x == 10'd0) begin
         if (pixel_y == OrgY) begin
            row_d   = '0;
            sub_y_d = '0;
         end else if (row_q < RowsOut) begin
            if (sub_y_q == SubLast) begin
               sub_y_d = '0;
               row_d   = row_q + 1'b1;
            end else begin
               sub_y_d = sub_y_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q   <= ColsOut;
         row_q   <= RowsOut;
         sub_x_q <= '0;
         sub_y_q <= '0;
      end else if (p_tick) begin
         col_q   <= col_d;
         row_q   <= row_d;
         sub_x_q <= sub_x_d;
         sub_y_q <= sub_y_d;
      end
   end

   assign cell_x = CxW'(col_q);
   assign cell_y = CyW'(row_q);

   logic inside_s0;
   assign inside_s0 = (col_q < ColsOut) && (row_q < RowsOut);

`ifdef BOARD_RENDER_GRIDLINE_EN
   localparam int unsigned AuxW = 1 + 2 * SubW;
   logic [AuxW-1:0] aux_in;
   assign aux_in = {inside_s0, sub_x_q, sub_y_q};
`else
   localparam int unsigned AuxW = 1;
   logic [AuxW-1:0] aux_in;
   assign aux_in = inside_s0;
`endif

   logic [2:0]      sync_dly;
   logic [AuxW-1:0] aux_dly;

   // Raw timing enters one stage earlier than the stage-0 derived signals.
   pix_delay #(
      .WIDTH (3),
      .DEPTH (RD_LAT + 1)
   ) u_sync_dly (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .en_i   (p_tick),
      .d_i    ({visible, hsync_in, vsync_in}),
      .q_o    (sync_dly)
   );

   pix_delay #(
      .WIDTH (AuxW),
      .DEPTH (RD_LAT)
   ) u_aux_dly (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .en_i   (p_tick),
      .d_i    (aux_in),
      .q_o    (aux_dly)
   );

   logic [11:0] rgb_q, rgb_d;
   logic        hsync_q, vsync_q;

   always_comb begin
      rgb_d = ColBg;
      if (sync_dly[2] && aux_dly[AuxW-1]) begin
         rgb_d = palette(kind_t'(cell_kind));
`ifdef BOARD_RENDER_GRIDLINE_EN
         if ((aux_dly[2*SubW-1:SubW] == '0) || (aux_dly[SubW-1:0] == '0)) rgb_d = ColGrid;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q   <= ColBg;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else if (p_tick) begin
         rgb_q   <= rgb_d;
         hsync_q <= sync_dly[1];
         vsync_q <= sync_dly[0];
      end
   end

   assign rgb       = rgb_q;
   assign hsync_out = hsync_q;
   assign vsync_out = vsync_q;

endmodule
